// File: rtl/javk_mem.sv
// javk_mem: bus responder for the JAVK CPU external bus.
// Serves an on-chip RAM with asynchronous read and a memory-mapped console
// page: a TX FIFO toward the console sink and a single-entry RX holding register.
module javk_mem #(
    parameter int RAM_AW   = 12,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addrbus,
    input  logic        rw,
    inout  wire  [7:0]  databus,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready
);

    localparam int PW = $clog2(TX_DEPTH);   // FIFO pointer width
    localparam int CW = PW + 1;             // FIFO count width (0..TX_DEPTH)

    localparam logic [15:0] ADDR_TXDATA  = 16'hFFF0;
    localparam logic [15:0] ADDR_STATUS  = 16'hFFF1;
    localparam logic [15:0] ADDR_RXDATA  = 16'hFFF2;
    localparam logic [15:0] ADDR_TXCOUNT = 16'hFFF3;

    localparam logic [CW-1:0] FULL_COUNT = CW'(TX_DEPTH);

    // Storage
    logic [7:0]    ram     [2**RAM_AW];
    logic [7:0]    tx_mem  [TX_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          tx_overflow;
    logic          rx_full;
    logic [7:0]    rx_hold;

    // Decode and handshake terms
    logic       ram_sel;
    logic       tx_full;
    logic       tx_empty;
    logic       push_req;
    logic       pop;
    logic       push;
    logic       capture;
    logic       rx_release;
    logic [7:0] rdata;

    assign ram_sel    = (addrbus[15:RAM_AW] == '0);
    assign tx_full    = (count == FULL_COUNT);
    assign tx_empty   = (count == '0);
    assign tx_valid   = !tx_empty;
    assign rx_ready   = !rx_full;

    assign push_req   = rw && (addrbus == ADDR_TXDATA);
    assign pop        = tx_valid && tx_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push       = push_req && (!tx_full || pop);
    assign capture    = rx_valid_in && rx_ready;
    assign rx_release = rw && (addrbus == ADDR_RXDATA);

    // The head reads as zero while empty, so tx_data is 0x00 out of reset.
    assign tx_data    = tx_empty ? 8'h00 : tx_mem[rd_ptr];

    // Combinational read mux: zero-latency, no side effects.
    always_comb begin
        // NOTE: default assigned first so every path drives rdata and no latch is inferred.
        rdata = 8'h00;
        if (ram_sel) begin
            rdata = ram[addrbus[RAM_AW-1:0]];
        end else begin
            case (addrbus)
                ADDR_STATUS:  rdata = {4'b0000, tx_overflow, rx_full, tx_empty, tx_full};
                ADDR_RXDATA:  rdata = rx_hold;
                ADDR_TXCOUNT: rdata = {{(8-CW){1'b0}}, count};
                default:      rdata = 8'h00;
            endcase
        end
    end

    // Drive the bus only while the CPU is reading.
    assign databus = rw ? 8'hzz : rdata;

    // RAM and FIFO storage writes; data arrays have no reset.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are deliberately not reset; only control state is,
        // which keeps RAM contents across rst and lets these map to memory macros.
        if (!rst) begin
            if (rw && ram_sel) begin
                ram[addrbus[RAM_AW-1:0]] <= databus;
            end
            if (push) begin
                tx_mem[wr_ptr] <= databus;
            end
        end
    end

    // TX FIFO control: pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all state samples pre-edge values.
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (rw && addrbus == ADDR_STATUS) begin
                tx_overflow <= 1'b0;
            end else if (push_req && !push) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    // RX holding register: capture when empty, release on RXDATA write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_full <= 1'b0;
            rx_hold <= 8'h00;
        end else if (rx_release) begin
            rx_full <= 1'b0;
        end else if (capture) begin
            rx_full <= 1'b1;
            rx_hold <= rx_data_in;
        end
    end

endmodule
